pixel_stream_fifo: RTL and testbench
====================================

Name: pixel_stream_fifo

Overview:
Parametrised single-clock pixel FIFO in pure RTL, with no vendor IP. It buffers CNN input features in the i_sys_clk domain between the SPI deserialiser (after its CDC stage) and the convolution front end. It is first-word-fall-through and tags each word with a start-of-frame bit. It reports occupancy, almost-full/almost-empty and sticky overflow/underflow errors, and supports a synchronous flush.

Parameters:
DATA_W, 8, feature word width in bits
DEPTH, 1024, number of entries; must be a power of two and at least 4
AFULL_THRESH, DEPTH-4, o_almost_full asserts when count >= this value
AEMPTY_THRESH, 4, o_almost_empty asserts when count <= this value

Ports:
i_sys_clk  in  1  system clock; all logic is on its rising edge
i_rst  in  1  asynchronous, active-high reset
i_flush  in  1  synchronous clear of contents
i_wr_en  in  1  push request
i_feature  in  DATA_W  push data
i_sof  in  1  start-of-frame tag stored with the word
i_rd_en  in  1  pop; acknowledges the current head word
o_feature_valid  out  1  head word present (FIFO not empty)
o_feature  out  DATA_W  head word data
o_sof  out  1  head word SOF tag
o_full  out  1  count == DEPTH
o_almost_full  out  1  count >= AFULL_THRESH
o_almost_empty  out  1  count <= AEMPTY_THRESH
o_count  out  $clog2(DEPTH)+1  current occupancy
o_overflow  out  1  sticky: a push was rejected
o_underflow  out  1  sticky: a pop occurred while empty
i_clr_err  in  1  synchronous clear of the sticky flags

Behaviour:
- Reset values (asynchronous, on i_rst high):
  - write pointer, read pointer and count = 0
  - o_feature_valid = 0, o_full = 0, o_almost_full = 0
  - o_almost_empty = 1
  - o_overflow = 0, o_underflow = 0
  - storage contents are not reset
- Pointers: $clog2(DEPTH) bits each, natural wrap from DEPTH-1 to 0. Count is held separately, $clog2(DEPTH)+1 bits.
- Storage is an array of DATA_W+1 bits (data plus SOF). Writes are synchronous; reads are asynchronous at the read pointer.
  - o_feature and o_sof = mem[rd_ptr]
  - o_feature_valid = (count != 0)
- Latency: a word pushed at edge N is visible on o_feature with o_feature_valid=1 after edge N (one cycle). Pop takes effect at the edge where i_rd_en=1.
- Push accepted iff i_wr_en=1 and count<DEPTH. On acceptance: write mem[wr_ptr], increment wr_ptr.
- Push while full is rejected, even when a pop occurs in the same cycle. Data is dropped and o_overflow is set next cycle.
- Pop accepted iff i_rd_en=1 and count>0. On acceptance: increment rd_ptr.
- Pop while empty: no state change; o_underflow is set next cycle.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Count update per edge: +1 for push only, -1 for pop only, otherwise unchanged.
- Flush has priority over push and pop in the same cycle. On flush: pointers and count = 0, and the push in that cycle is discarded. Sticky flags are unchanged by flush; a push or pop error in the flush cycle is not flagged.
- i_clr_err clears both sticky flags. If a new error occurs in the same cycle, set wins.
- Status outputs o_full, o_almost_full, o_almost_empty are registered from next-state count. They are therefore consistent with o_count in every cycle.
- Threshold checks: elaboration-time assertion that 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); the first push is accepted at the first edge after release.

Decomposition:
- pixel_fifo_pkg holds:
  - default DATA_W
  - a typedef for the stored word (struct: logic sof, logic [DATA_W-1:0] data)
  - the count-width helper constant
- One sub-module, pixel_fifo_ram: simple-dual-port, synchronous write, asynchronous read, parametrised width and depth, inferred as distributed or LUT RAM.
- Pointer, count, flag and status logic stays in pixel_stream_fifo.

Test Plan:
- Reset, then push 0x11 (sof=1), 0x22, 0x33 with no pops -> valid=1 one cycle after the first push, o_feature=0x11, o_sof=1, o_count=3, o_almost_empty=1.
- DEPTH=8, AFULL_THRESH=6: push 8 words, then push 0xAA -> o_full=1, o_almost_full=1 from count 6, o_overflow=1, 0xAA never appears; popping all 8 returns words in order.
- Pop on empty after reset -> o_underflow=1 and count stays 0. Then assert i_clr_err -> o_underflow=0.
- Hold push and pop together at count=3 for 20 cycles with an incrementing pattern -> count stays 3 and output is the input delayed by 3 words. Repeat at count=DEPTH: push is rejected and overflow is set.
- Count=5, assert i_flush together with i_wr_en -> next cycle count=0, valid=0, full=0. Words pushed afterwards start at the new head.
- Assert i_rst asynchronously mid-stream (between clock edges) -> outputs take reset values before the next edge; wrap-around test of 3*DEPTH words after release shows no loss or reordering.

Source files
------------

// File: rtl/pixel_fifo_pkg.sv
// Shared constants and types for the pixel FIFO slice.
package pixel_fifo_pkg;

   localparam int DEFAULT_DATA_W = 8;

   // Stored word at the default width: SOF tag above the feature data.
   typedef struct packed {
      logic                      sof;
      logic [DEFAULT_DATA_W-1:0] data;
   } pixel_word_t;

   // Occupancy needs one bit more than the pointers so DEPTH itself is representable.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pixel_fifo_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read (maps to LUT RAM).
module pixel_fifo_ram #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_stream_fifo.sv
// First-word-fall-through pixel FIFO with SOF tagging, occupancy status,
// sticky overflow/underflow flags and synchronous flush.
module pixel_stream_fifo
   import pixel_fifo_pkg::*;
#(
   parameter int DATA_W        = DEFAULT_DATA_W,
   parameter int DEPTH         = 1024,
   parameter int AFULL_THRESH  = DEPTH - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                          i_sys_clk,
   input  logic                          i_rst,
   input  logic                          i_flush,
   input  logic                          i_wr_en,
   input  logic [DATA_W-1:0]             i_feature,
   input  logic                          i_sof,
   input  logic                          i_rd_en,
   output logic                          o_feature_valid,
   output logic [DATA_W-1:0]             o_feature,
   output logic                          o_sof,
   output logic                          o_full,
   output logic                          o_almost_full,
   output logic                          o_almost_empty,
   output logic [count_width(DEPTH)-1:0] o_count,
   output logic                          o_overflow,
   output logic                          o_underflow,
   input  logic                          i_clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pixel_stream_fifo: DEPTH must be a power of two and at least 4");
   end
   if (!(AEMPTY_THRESH > 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
      $error("pixel_stream_fifo: need 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
   end

   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]     count_reg, count_next;
   logic              full_reg, afull_reg, aempty_reg;
   logic              overflow_reg, underflow_reg;
   logic              overflow_next, underflow_next;
   logic              push_ok, pop_ok, ovf_event, udf_event;
   logic              is_full, is_empty;
   logic [DATA_W:0]   head_word;

   assign is_full  = (count_reg == CW'(DEPTH));
   assign is_empty = (count_reg == '0);

   // A full FIFO rejects a push even if a pop frees a slot in the same cycle.
   always_comb begin
      push_ok   = i_wr_en && !is_full  && !i_flush;
      pop_ok    = i_rd_en && !is_empty && !i_flush;
      ovf_event = i_wr_en &&  is_full  && !i_flush;
      udf_event = i_rd_en &&  is_empty && !i_flush;
   end

   always_comb begin
      count_next = count_reg;
      if (i_flush) begin
         count_next = '0;
      end else if (push_ok && !pop_ok) begin
         count_next = count_reg + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_next = count_reg - CW'(1);
      end
   end

   // A new error wins over a clear in the same cycle.
   always_comb begin
      overflow_next  = ovf_event || (overflow_reg  && !i_clr_err);
      underflow_next = udf_event || (underflow_reg && !i_clr_err);
   end

   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         afull_reg     <= 1'b0;
         aempty_reg    <= 1'b1;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg     <= count_next;
         full_reg      <= (count_next == CW'(DEPTH));
         afull_reg     <= (count_next >= CW'(AFULL_THRESH));
         aempty_reg    <= (count_next <= CW'(AEMPTY_THRESH));
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   pixel_fifo_ram #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (i_sys_clk),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr_reg),
      .wr_data ({i_sof, i_feature}),
      .rd_addr (rd_ptr_reg),
      .rd_data (head_word)
   );

   assign o_feature_valid = !is_empty;
   assign o_feature       = head_word[DATA_W-1:0];
   assign o_sof           = head_word[DATA_W];
   assign o_count         = count_reg;
   assign o_full          = full_reg;
   assign o_almost_full   = afull_reg;
   assign o_almost_empty  = aempty_reg;
   assign o_overflow      = overflow_reg;
   assign o_underflow     = underflow_reg;

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Randomised and directed bench for pixel_stream_fifo against a queue-based reference model.
module tb_pixel_stream_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int AFULL  = 6;
   localparam int AEMPTY = 4;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_flush = 1'b0;
   logic              i_wr_en = 1'b0;
   logic [DATA_W-1:0] i_feature = '0;
   logic              i_sof = 1'b0;
   logic              i_rd_en = 1'b0;
   logic              i_clr_err = 1'b0;
   logic              o_feature_valid;
   logic [DATA_W-1:0] o_feature;
   logic              o_sof;
   logic              o_full;
   logic              o_almost_full;
   logic              o_almost_empty;
   logic [CW-1:0]     o_count;
   logic              o_overflow;
   logic              o_underflow;

   always #5 clk = ~clk;

   pixel_stream_fifo #(
      .DATA_W        (DATA_W),
      .DEPTH         (DEPTH),
      .AFULL_THRESH  (AFULL),
      .AEMPTY_THRESH (AEMPTY)
   ) dut (
      .i_sys_clk       (clk),
      .i_rst           (i_rst),
      .i_flush         (i_flush),
      .i_wr_en         (i_wr_en),
      .i_feature       (i_feature),
      .i_sof           (i_sof),
      .i_rd_en         (i_rd_en),
      .o_feature_valid (o_feature_valid),
      .o_feature       (o_feature),
      .o_sof           (o_sof),
      .o_full          (o_full),
      .o_almost_full   (o_almost_full),
      .o_almost_empty  (o_almost_empty),
      .o_count         (o_count),
      .o_overflow      (o_overflow),
      .o_underflow     (o_underflow),
      .i_clr_err       (i_clr_err)
   );

   // Reference model: a queue of {sof, data} words plus the two sticky flags.
   logic [DATA_W:0] model_q[$];
   bit              m_ovf = 1'b0;
   bit              m_udf = 1'b0;
   int              checks_total  = 0;
   int              checks_passed = 0;
   int              txn = 0;

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("FAIL %s (txn %0d): got 0x%0h, expected 0x%0h", tag, txn, actual, expected);
   endtask

   task automatic check_state();
      int n;
      n = model_q.size();
      check_eq("valid", o_feature_valid, n != 0);
      if (n != 0) begin
         check_eq("feature", o_feature, model_q[0][DATA_W-1:0]);
         check_eq("sof", o_sof, model_q[0][DATA_W]);
      end
      check_eq("count", o_count, n);
      check_eq("full", o_full, n == DEPTH);
      check_eq("almost_full", o_almost_full, n >= AFULL);
      check_eq("almost_empty", o_almost_empty, n <= AEMPTY);
      check_eq("overflow", o_overflow, m_ovf);
      check_eq("underflow", o_underflow, m_udf);
   endtask

   task automatic step(input bit wr, input logic [DATA_W-1:0] d, input bit s,
                       input bit rd, input bit fl, input bit clr);
      int n;
      @(negedge clk);
      i_wr_en = wr; i_feature = d; i_sof = s; i_rd_en = rd; i_flush = fl; i_clr_err = clr;
      @(posedge clk);
      n = model_q.size();
      if (clr) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      if (fl) begin
         model_q.delete();
      end else begin
         if (wr && n == DEPTH) m_ovf = 1'b1;
         if (rd && n == 0)     m_udf = 1'b1;
         if (rd && n > 0)      void'(model_q.pop_front());
         if (wr && n < DEPTH)  model_q.push_back({s, d});
      end
      #1;
      txn++;
      $display("txn %0d: wr=%0d d=0x%02h sof=%0d rd=%0d flush=%0d clr=%0d -> count=%0d valid=%0d head=0x%02h",
               txn, wr, d, s, rd, fl, clr, o_count, o_feature_valid, o_feature);
      check_state();
   endtask

   task automatic async_reset();
      @(negedge clk);
      i_wr_en = 1'b0; i_rd_en = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
      #2 i_rst = 1'b1;
      #1;
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      txn++;
      $display("txn %0d: async reset asserted between edges", txn);
      check_state();
      #1 i_rst = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] pat;
      int pushed;

      // Hold reset across a couple of edges, release, then check reset state.
      repeat (2) @(posedge clk);
      @(negedge clk) i_rst = 1'b0;
      #1 check_state();

      // Directed fill with SOF on the first word.
      step(1, 8'h11, 1, 0, 0, 0);
      step(1, 8'h22, 0, 0, 0, 0);
      step(1, 8'h33, 0, 0, 0, 0);
      check_eq("head_after_3", o_feature, 32'h11);
      check_eq("count_after_3", o_count, 3);

      // Fill to full, then push 0xAA into a full FIFO twice.
      for (int i = 0; i < 5; i++) step(1, 8'h40 + 8'(i), 0, 0, 0, 0);
      step(1, 8'hAA, 1, 0, 0, 0);
      step(1, 8'hAA, 1, 0, 0, 0);
      check_eq("overflow_set", o_overflow, 1);
      for (int i = 0; i < DEPTH; i++) begin
         check_eq("drain_not_aa", (o_feature == 8'hAA), 0);
         step(0, 8'h00, 0, 1, 0, 0);
      end

      // Pop on empty, then clear the sticky flags.
      step(0, 8'h00, 0, 1, 0, 0);
      check_eq("underflow_set", o_underflow, 1);
      step(0, 8'h00, 0, 0, 0, 1);
      check_eq("underflow_clr", o_underflow, 0);

      // Steady state at count 3 with simultaneous push and pop.
      pat = 8'h01;
      for (int i = 0; i < 3; i++) begin step(1, pat, 0, 0, 0, 0); pat++; end
      for (int i = 0; i < 20; i++) begin step(1, pat, 0, 1, 0, 0); pat++; end
      check_eq("steady_head", o_feature, 32'(pat - 8'd3));

      // Push and pop together at full: push rejected, pop accepted.
      for (int i = 0; i < 5; i++) begin step(1, pat, 0, 0, 0, 0); pat++; end
      step(1, 8'hEE, 0, 1, 0, 0);
      check_eq("full_pushpop_ovf", o_overflow, 1);
      check_eq("full_pushpop_cnt", o_count, DEPTH - 1);

      // Error clear and a fresh error in the same cycle: set wins.
      step(0, 8'h00, 0, 0, 1, 0);
      step(0, 8'h00, 0, 1, 0, 1);
      check_eq("clr_vs_set", o_underflow, 1);
      step(0, 8'h00, 0, 0, 0, 1);

      // Flush at count 5 with a simultaneous push.
      for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0, 0, 0);
      step(1, 8'h77, 0, 0, 1, 0);
      check_eq("flush_count", o_count, 0);
      step(1, 8'h88, 1, 0, 0, 0);
      check_eq("flush_new_head", o_feature, 32'h88);

      // Random traffic with occasional flush and error clear.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 99) < 55, 8'($urandom), 1'($urandom),
              $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 5);
      end

      // Asynchronous reset mid-stream, then a wrap-around run of 3*DEPTH words.
      for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0, 0, 0, 0);
      async_reset();
      pushed = 0;
      pat = 8'hC0;
      while (pushed < 3 * DEPTH) begin
         if (model_q.size() < DEPTH) begin
            step(1, pat, pushed % DEPTH == 0, $urandom_range(0, 1) == 1, 0, 0);
            pat++;
            pushed++;
         end else begin
            step(0, 8'h00, 0, 1, 0, 0);
         end
      end
      while (model_q.size() > 0) step(0, 8'h00, 0, 1, 0, 0);
      check_eq("wrap_final_count", o_count, 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
